// File: rtl/arith_pkg.sv
// Opcode and FSM state encodings shared by the arithmetic unit and the control unit.
package arith_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_DIV = 2'b10;
   localparam logic [1:0] OP_MUL = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      DONE = 2'b10
   } state_t;

endpackage

// File: rtl/seq_muldiv_core.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one bit per cycle.
module seq_muldiv_core #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   logic             run_q, run_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             div_q;
   logic [WIDTH-1:0] hi_q, lo_q, b_q;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH+1:0] div_diff;
   logic [WIDTH-1:0] step_hi, step_lo;

   // hi_q holds the partial product high half (MUL) or running remainder (DIV);
   // lo_q holds the remaining multiplier bits (MUL) or dividend/quotient (DIV).
   always_comb begin
      mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
      div_diff = {1'b0, hi_q, lo_q[WIDTH-1]} - {2'b00, b_q};
      if (div_q) begin
         step_hi = div_diff[WIDTH+1] ? {hi_q[WIDTH-2:0], lo_q[WIDTH-1]} : div_diff[WIDTH-1:0];
         step_lo = {lo_q[WIDTH-2:0], ~div_diff[WIDTH+1]};
      end else begin
         step_hi = mul_sum[WIDTH:1];
         step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
      end
   end

   always_comb begin
      run_d = run_q;
      cnt_d = cnt_q;
      if (start) begin
         run_d = 1'b1;
         cnt_d = '0;
      end else if (run_q) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == CNT_W'(WIDTH - 1)) run_d = 1'b0;
      end
   end

   // done flags the final iteration; hi/lo carry that iteration's result so the
   // caller can register it on the same edge.
   assign done = run_q && (cnt_q == CNT_W'(WIDTH - 1));
   assign hi   = step_hi;
   assign lo   = step_lo;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         run_q <= run_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         hi_q  <= '0;
         lo_q  <= a;
         b_q   <= b;
         div_q <= is_div;
      end else if (run_q) begin
         hi_q  <= step_hi;
         lo_q  <= step_lo;
      end
   end

endmodule

// File: rtl/seq_arith_unit.sv
// Handshaked ADD/SUB/DIV/MUL unit: 1-cycle ADD/SUB, WIDTH-cycle iterative MUL/DIV.
module seq_arith_unit
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             carry,
   output logic             zero,
   output logic             dbz,
   output logic             busy
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] lo_q, lo_d, hi_q, hi_d;
   logic             carry_q, carry_d, zero_q, zero_d, dbz_q, dbz_d;
   logic             accept, b_is_zero, core_start, core_done;
   logic [WIDTH-1:0] core_hi, core_lo;
   logic [WIDTH:0]   add_full, sub_full;

   assign accept     = in_valid && (state_q == IDLE);
   assign b_is_zero  = (b == '0);
   assign core_start = accept && ((op == OP_MUL) || ((op == OP_DIV) && !b_is_zero));
   assign add_full   = {1'b0, a} + {1'b0, b};
   assign sub_full   = {1'b0, a} - {1'b0, b};

   seq_muldiv_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .rst    (rst),
      .start  (core_start),
      .is_div (op == OP_DIV),
      .a      (a),
      .b      (b),
      .done   (core_done),
      .hi     (core_hi),
      .lo     (core_lo)
   );

   always_comb begin
      state_d = state_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      carry_d = carry_q;
      zero_d  = zero_q;
      dbz_d   = dbz_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (op)
                  OP_ADD: begin
                     lo_d    = add_full[WIDTH-1:0];
                     hi_d    = '0;
                     carry_d = add_full[WIDTH];
                     zero_d  = (add_full[WIDTH-1:0] == '0);
                     state_d = DONE;
                  end
                  OP_SUB: begin
                     lo_d    = sub_full[WIDTH-1:0];
                     hi_d    = '0;
                     carry_d = sub_full[WIDTH];
                     zero_d  = (sub_full[WIDTH-1:0] == '0);
                     state_d = DONE;
                  end
                  OP_DIV: begin
                     if (b_is_zero) begin
                        lo_d    = '1;
                        hi_d    = a;
                        carry_d = 1'b0;
                        zero_d  = 1'b0;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                     end else begin
                        state_d = CALC;
                     end
                  end
                  default: state_d = CALC;
               endcase
            end
         end
         CALC: begin
            if (core_done) begin
               lo_d    = core_lo;
               hi_d    = core_hi;
               carry_d = 1'b0;
               zero_d  = ({core_hi, core_lo} == '0);
               dbz_d   = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
            // Result and flags are only meaningful while out_valid is high.
            if (out_ready) begin
               lo_d    = '0;
               hi_d    = '0;
               carry_d = 1'b0;
               zero_d  = 1'b0;
               dbz_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         lo_q    <= '0;
         hi_q    <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         carry_q <= carry_d;
         zero_q  <= zero_d;
         dbz_q   <= dbz_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign result_lo = lo_q;
   assign result_hi = hi_q;
   assign carry     = carry_q;
   assign zero      = zero_q;
   assign dbz       = dbz_q;

endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed bench for seq_arith_unit at WIDTH=8 and WIDTH=16.
module tb_seq_arith_unit;
   import arith_pkg::*;

   typedef struct {
      logic [1:0]  op;
      logic [15:0] a, b, lo, hi;
      logic        c, z, d;
      int          lat;
   } vec_t;

   logic        clk, rst, in_valid, out_ready, sel16;
   logic [1:0]  op;
   logic [15:0] a, b;

   logic        r8_in_ready, r8_out_valid, r8_carry, r8_zero, r8_dbz, r8_busy;
   logic [7:0]  r8_lo, r8_hi;
   logic        r16_in_ready, r16_out_valid, r16_carry, r16_zero, r16_dbz, r16_busy;
   logic [15:0] r16_lo, r16_hi;

   logic        o_in_ready, o_out_valid, o_carry, o_zero, o_dbz, o_busy;
   logic [15:0] o_lo, o_hi;

   int errors = 0;
   int checks = 0;

   vec_t t8[15];
   vec_t t16[10];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   seq_arith_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid && !sel16), .in_ready(r8_in_ready),
      .op(op), .a(a[7:0]), .b(b[7:0]), .out_valid(r8_out_valid), .out_ready(out_ready),
      .result_lo(r8_lo), .result_hi(r8_hi), .carry(r8_carry), .zero(r8_zero),
      .dbz(r8_dbz), .busy(r8_busy)
   );

   seq_arith_unit #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .in_valid(in_valid && sel16), .in_ready(r16_in_ready),
      .op(op), .a(a), .b(b), .out_valid(r16_out_valid), .out_ready(out_ready),
      .result_lo(r16_lo), .result_hi(r16_hi), .carry(r16_carry), .zero(r16_zero),
      .dbz(r16_dbz), .busy(r16_busy)
   );

   always_comb begin
      if (sel16) begin
         o_in_ready = r16_in_ready; o_out_valid = r16_out_valid; o_carry = r16_carry;
         o_zero = r16_zero; o_dbz = r16_dbz; o_busy = r16_busy; o_lo = r16_lo; o_hi = r16_hi;
      end else begin
         o_in_ready = r8_in_ready; o_out_valid = r8_out_valid; o_carry = r8_carry;
         o_zero = r8_zero; o_dbz = r8_dbz; o_busy = r8_busy;
         o_lo = {8'h00, r8_lo}; o_hi = {8'h00, r8_hi};
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (W=%0d): got %0h expected %0h", name, sel16 ? 16 : 8, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int lat;
      check({tag, " in_ready"}, o_in_ready, 1);
      op = v.op; a = v.a; b = v.b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom);
      lat = 1;
      while (!o_out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check({tag, " latency"}, lat, v.lat);
      check({tag, " lo"}, o_lo, v.lo);
      check({tag, " hi"}, o_hi, v.hi);
      check({tag, " carry"}, o_carry, v.c);
      check({tag, " zero"}, o_zero, v.z);
      check({tag, " dbz"}, o_dbz, v.d);
      check({tag, " busy"}, o_busy, 1);
      @(posedge clk); #1;
      check({tag, " release valid"}, o_out_valid, 0);
      check({tag, " release lo"}, o_lo, 0);
   endtask

   task automatic corners(input logic [15:0] ma, input logic [15:0] mb,
                          input logic [15:0] elo, input logic [15:0] ehi, input int lat);
      int n;
      vec_t v;
      out_ready = 1'b0;
      op = OP_MUL; a = ma; b = mb; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 1;
      repeat (3) begin
         @(posedge clk); #1;
         a = ~a; b = b + 16'd1;
         n++;
      end
      while (!o_out_valid && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      check("bp latency", n, lat);
      in_valid = 1'b1; op = OP_ADD;
      repeat (5) begin
         @(posedge clk); #1;
         check("bp valid", o_out_valid, 1);
         check("bp lo", o_lo, elo);
         check("bp hi", o_hi, ehi);
         check("bp in_ready", o_in_ready, 0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp released", o_out_valid, 0);
      check("bp idle", o_in_ready, 1);

      // Reset while the divider is in its fourth CALC cycle.
      op = OP_DIV; a = 16'd40; b = 16'd8; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("mid-div in_ready", o_in_ready, 0);
      #2 rst = 1'b0;
      #1;
      check("rst valid", o_out_valid, 0);
      check("rst in_ready", o_in_ready, 1);
      check("rst busy", o_busy, 0);
      check("rst lo", o_lo, 0);
      check("rst hi", o_hi, 0);
      #2 rst = 1'b1;
      @(posedge clk); #1;
      v = '{OP_ADD, 16'd1, 16'd1, 16'd2, 16'd0, 1'b0, 1'b0, 1'b0, 1};
      run_vec(v, "post-rst add");
   endtask

   initial begin
      t8[0]  = '{OP_ADD, 16'd5,   16'd3,   16'd8,    16'd0,    1'b0, 1'b0, 1'b0, 1};
      t8[1]  = '{OP_ADD, 16'd200, 16'd100, 16'd44,   16'd0,    1'b1, 1'b0, 1'b0, 1};
      t8[2]  = '{OP_ADD, 16'd255, 16'd1,   16'd0,    16'd0,    1'b1, 1'b1, 1'b0, 1};
      t8[3]  = '{OP_SUB, 16'd8,   16'd3,   16'd5,    16'd0,    1'b0, 1'b0, 1'b0, 1};
      t8[4]  = '{OP_SUB, 16'd3,   16'd8,   16'd251,  16'd0,    1'b1, 1'b0, 1'b0, 1};
      t8[5]  = '{OP_SUB, 16'd7,   16'd7,   16'd0,    16'd0,    1'b0, 1'b1, 1'b0, 1};
      t8[6]  = '{OP_DIV, 16'd40,  16'd8,   16'd5,    16'd0,    1'b0, 1'b0, 1'b0, 9};
      t8[7]  = '{OP_DIV, 16'd7,   16'd0,   16'd255,  16'd7,    1'b0, 1'b0, 1'b1, 1};
      t8[8]  = '{OP_DIV, 16'd200, 16'd3,   16'd66,   16'd2,    1'b0, 1'b0, 1'b0, 9};
      t8[9]  = '{OP_DIV, 16'd255, 16'd16,  16'd15,   16'd15,   1'b0, 1'b0, 1'b0, 9};
      t8[10] = '{OP_DIV, 16'd3,   16'd10,  16'd0,    16'd3,    1'b0, 1'b0, 1'b0, 9};
      t8[11] = '{OP_MUL, 16'd6,   16'd7,   16'd42,   16'd0,    1'b0, 1'b0, 1'b0, 9};
      t8[12] = '{OP_MUL, 16'd200, 16'd200, 16'h40,   16'h9C,   1'b0, 1'b0, 1'b0, 9};
      t8[13] = '{OP_MUL, 16'd255, 16'd255, 16'h01,   16'hFE,   1'b0, 1'b0, 1'b0, 9};
      t8[14] = '{OP_MUL, 16'd0,   16'd77,  16'd0,    16'd0,    1'b0, 1'b1, 1'b0, 9};

      t16[0] = '{OP_ADD, 16'd5,     16'd3,     16'd8,     16'd0,     1'b0, 1'b0, 1'b0, 1};
      t16[1] = '{OP_ADD, 16'd60000, 16'd10000, 16'd4464,  16'd0,     1'b1, 1'b0, 1'b0, 1};
      t16[2] = '{OP_SUB, 16'd3,     16'd8,     16'd65531, 16'd0,     1'b1, 1'b0, 1'b0, 1};
      t16[3] = '{OP_SUB, 16'd7,     16'd7,     16'd0,     16'd0,     1'b0, 1'b1, 1'b0, 1};
      t16[4] = '{OP_DIV, 16'd40,    16'd8,     16'd5,     16'd0,     1'b0, 1'b0, 1'b0, 17};
      t16[5] = '{OP_DIV, 16'd7,     16'd0,     16'hFFFF,  16'd7,     1'b0, 1'b0, 1'b1, 1};
      t16[6] = '{OP_DIV, 16'd1000,  16'd7,     16'd142,   16'd6,     1'b0, 1'b0, 1'b0, 17};
      t16[7] = '{OP_MUL, 16'd200,   16'd200,   16'd40000, 16'd0,     1'b0, 1'b0, 1'b0, 17};
      t16[8] = '{OP_MUL, 16'd60000, 16'd60000, 16'hA400,  16'hD693,  1'b0, 1'b0, 1'b0, 17};
      t16[9] = '{OP_MUL, 16'hFFFF,  16'hFFFF,  16'h0001,  16'hFFFE,  1'b0, 1'b0, 1'b0, 17};

      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = OP_ADD;
      a = '0; b = '0; sel16 = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sel16 = (s == 1);
         #1;
         check("reset in_ready", o_in_ready, 1);
         check("reset out_valid", o_out_valid, 0);
         check("reset busy", o_busy, 0);
         check("reset lo", o_lo, 0);
         check("reset flags", {o_carry, o_zero, o_dbz}, 0);
      end
      sel16 = 1'b0;
      #2 rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 15; i++) run_vec(t8[i], $sformatf("w8 vec%0d", i));
      corners(16'd200, 16'd200, 16'h0040, 16'h009C, 9);

      sel16 = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) run_vec(t16[i], $sformatf("w16 vec%0d", i));
      corners(16'd60000, 16'd60000, 16'hA400, 16'hD693, 17);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
